led_axil_arbiter: RTL

Shares one AXI4-Lite master port between two local command requesters and sequences single-beat register accesses into the LED control slave (four 32-bit registers at byte offsets 0x0/0x4/0x8/0xC). It sits between on-chip requesters (e.g. PS-side control logic and a local pattern engine) and the LED control register bank.
- Round-robin arbitration.
- One outstanding transaction at a time.
- Response-phase watchdog with a sticky fault.

---
 rtl/led_axil_arbiter_if.sv | 40 ++++
 rtl/led_axil_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/led_axil_arbiter_if.sv
// AXI4-Lite single-master bus bundle between the LED arbiter and the LED control register bank.
interface led_axil_arbiter_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/led_axil_arbiter.sv
// Two-requester round-robin front end that serialises single-beat accesses onto one AXI4-Lite
// master port, with a response watchdog that latches a sticky fault and halts further grants.
module led_axil_arbiter #(
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 255
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [3:0]  req_idx,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        fault,
  led_axil_arbiter_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP, HALT} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic                  aw_pend, w_pend;
  logic [15:0]           cnt_q;
  logic                  err_q, fault_q, to_q;

  logic                  gnt_sel, take, expired;
  logic [1:0]            sel_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Both valid: the requester that did not win last time gets the grant.
  assign gnt_sel  = (req_valid == 2'b11) ? ~last_q : (req_valid == 2'b10);
  assign take     = (state_q == IDLE) && (|req_valid) && !ARESET;
  assign sel_idx  = req_idx[{gnt_sel, 1'b0} +: 2];
  assign sel_addr = BASE_ADDR + ADDR_WIDTH'({sel_idx, 2'b00});
  assign expired  = (cnt_q == 16'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = req_write[gnt_sel] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((!aw_pend || m_axi.awready) && (!w_pend || m_axi.wready)) state_d = WR_RESP;
      WR_RESP: if (m_axi.bvalid || expired) state_d = RESP;
      RD_ADDR: if (m_axi.arready) state_d = RD_DATA;
      RD_DATA: if (m_axi.rvalid || expired) state_d = RESP;
      RESP:    if (rsp_ready[grant_q]) state_d = to_q ? HALT : IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= gnt_sel;
        addr_q  <= sel_addr;
        wdata_q <= req_wdata[{gnt_sel, 5'd0} +: 32];
        aw_pend <= req_write[gnt_sel];
        w_pend  <= req_write[gnt_sel];
      end
      if (state_q == WR_ADDR) begin
        if (m_axi.awready) aw_pend <= 1'b0;
        if (m_axi.wready)  w_pend  <= 1'b0;
      end
      // Watchdog runs only while waiting on B/R; any other state holds it at zero.
      if (state_q == WR_RESP || state_q == RD_DATA) cnt_q <= cnt_q + 16'd1;
      else                                          cnt_q <= '0;
      if (state_q == WR_RESP && m_axi.bvalid) begin
        rdata_q <= '0;
        err_q   <= (m_axi.bresp != 2'b00);
        to_q    <= 1'b0;
      end else if (state_q == RD_DATA && m_axi.rvalid) begin
        rdata_q <= m_axi.rdata;
        err_q   <= (m_axi.rresp != 2'b00);
        to_q    <= 1'b0;
      end else if ((state_q == WR_RESP || state_q == RD_DATA) && expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        to_q    <= 1'b1;
        fault_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready[grant_q]) last_q <= grant_q;
    end
  end

  assign req_ready = take ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign fault     = fault_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_q == WR_ADDR) && aw_pend;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = (state_q == WR_ADDR) && w_pend;
  assign m_axi.bready  = (state_q == WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == RD_ADDR);
  assign m_axi.rready  = (state_q == RD_DATA);

endmodule
